// File: rtl/fractional_strobe_gen_pkg.sv
// Shared constants and increment helper for the fractional strobe generator.
// Phase increments are computed as round(2^ACC_W * f_out / f_clk).
package fractional_strobe_gen_pkg;

    localparam int unsigned DEF_ACC_W = 46;
    localparam logic [63:0] CLK_HZ    = 64'd48_000_000;
    localparam logic [63:0] DEF_OUT_HZ = 64'd2;

    // 2 Hz out of a 48 MHz clock on a 46-bit accumulator
    localparam logic [63:0] DEF_INC   = 64'd2_932_031;

    // Rounded increment; 128-bit intermediate keeps 2^acc_w * f_out exact.
    function automatic logic [63:0] calc_inc(
        input int unsigned acc_w,
        input logic [63:0] f_out,
        input logic [63:0] f_clk
    );
        logic [127:0] num;
        num = (128'(1) << acc_w) * 128'(f_out) + 128'(f_clk >> 1);
        return 64'(num / 128'(f_clk));
    endfunction

endpackage

// File: rtl/fractional_strobe_gen_strobe_channel.sv
// One strobe channel: phase accumulator, increment register and index counter.
// The strobe is the registered accumulator carry; the index advances while it is high.
module strobe_channel
    import fractional_strobe_gen_pkg::*;
#(
    parameter int unsigned       ACC_W   = DEF_ACC_W,
    parameter int unsigned       IDX_W   = 4,
    parameter logic [ACC_W-1:0]  DEF_INC = ACC_W'(1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic              i_inc_wr,
    input  logic [ACC_W-1:0]  i_inc_data,
    input  logic              i_clr,
    input  logic [IDX_W-1:0]  i_idx_max,
    output logic              o_stb,
    output logic [IDX_W-1:0]  o_index,
    output logic              o_wrap
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic [IDX_W-1:0] r_idx;
    logic             r_stb;
    logic             r_wrap;

    logic [ACC_W:0]   w_sum;
    logic             w_idx_term;

    assign w_sum      = {1'b0, r_acc} + {1'b0, r_inc};
    // All-ones also terminates so a lowered idx_max still rolls over naturally
    assign w_idx_term = (r_idx == i_idx_max) || (r_idx == {IDX_W{1'b1}});

    // Increment register; clear leaves it alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inc <= DEF_INC;
        end else if (i_inc_wr) begin
            r_inc <= i_inc_data;
        end
    end

    // Phase accumulator and registered carry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_stb <= 1'b0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_stb <= 1'b0;
        end else if (i_run) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_stb <= w_sum[ACC_W];
        end else begin
            r_stb <= 1'b0;
        end
    end

    // Index counter, stepped on the strobe cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx  <= '0;
            r_wrap <= 1'b0;
        end else if (i_clr) begin
            r_idx  <= '0;
            r_wrap <= 1'b0;
        end else if (r_stb) begin
            r_wrap <= w_idx_term;
            r_idx  <= w_idx_term ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign o_stb   = r_stb;
    assign o_index = r_idx;
    assign o_wrap  = r_wrap;

endmodule

// File: rtl/fractional_strobe_gen.sv
// Multi-channel fractional strobe generator: N_CH independent phase-accumulator
// channels, each producing a one-cycle strobe, an index and a wrap pulse.
module fractional_strobe_gen #(
    parameter int unsigned ACC_W   = 46,
    parameter int unsigned N_CH    = 2,
    parameter int unsigned IDX_W   = 4,
    parameter logic [63:0] DEF_INC = fractional_strobe_gen_pkg::DEF_INC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         run,
    input  logic [N_CH-1:0]         inc_wr,
    input  logic [ACC_W-1:0]        inc_data,
    input  logic [N_CH-1:0]         clr,
    input  logic [N_CH*IDX_W-1:0]   idx_max,
    output logic [N_CH-1:0]         stb,
    output logic [N_CH*IDX_W-1:0]   index,
    output logic [N_CH-1:0]         wrap
);

    import fractional_strobe_gen_pkg::*;

    localparam logic [ACC_W-1:0] CH_DEF_INC = ACC_W'(DEF_INC);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        strobe_channel #(
            .ACC_W   (ACC_W),
            .IDX_W   (IDX_W),
            .DEF_INC (CH_DEF_INC)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .i_run      (run[c]),
            .i_inc_wr   (inc_wr[c]),
            .i_inc_data (inc_data),
            .i_clr      (clr[c]),
            .i_idx_max  (idx_max[c*IDX_W +: IDX_W]),
            .o_stb      (stb[c]),
            .o_index    (index[c*IDX_W +: IDX_W]),
            .o_wrap     (wrap[c])
        );
    end

endmodule

// File: tb/tb_fractional_strobe_gen.sv
// Directed bench for fractional_strobe_gen with a 4-bit accumulator, two channels.
module tb_fractional_strobe_gen;

    import fractional_strobe_gen_pkg::*;

    localparam int unsigned ACC_W = 4;
    localparam int unsigned N_CH  = 2;
    localparam int unsigned IDX_W = 4;

    logic                  clk;
    logic                  reset;
    logic [N_CH-1:0]       run;
    logic [N_CH-1:0]       inc_wr;
    logic [ACC_W-1:0]      inc_data;
    logic [N_CH-1:0]       clr;
    logic [N_CH*IDX_W-1:0] idx_max;
    logic [N_CH-1:0]       stb;
    logic [N_CH*IDX_W-1:0] index;
    logic [N_CH-1:0]       wrap;

    int n_chk = 0;
    int n_bad = 0;

    // model state: edge count since phase start, per-channel inc/max/index/strobe
    int k;
    int m_inc [2];
    int m_max [2];
    int m_idx [2];
    int m_stb [2];

    fractional_strobe_gen #(
        .ACC_W   (ACC_W),
        .N_CH    (N_CH),
        .IDX_W   (IDX_W),
        .DEF_INC (64'd5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .inc_wr   (inc_wr),
        .inc_data (inc_data),
        .clr      (clr),
        .idx_max  (idx_max),
        .stb      (stb),
        .index    (index),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a phase with accumulators and indices known to be zero
    task automatic run_start();
        k = 0;
        for (int c = 0; c < 2; c++) begin
            m_idx[c] = 0;
            m_stb[c] = 0;
        end
    endtask

    // Strobe after edge k iff floor(inc*k/16) steps; index/wrap follow the previous strobe
    task automatic run_edges(input int n);
        int e_wrap [2];
        for (int i = 0; i < n; i++) begin
            k++;
            for (int c = 0; c < 2; c++) begin
                e_wrap[c] = 0;
                if (m_stb[c] != 0) begin
                    if (m_idx[c] == m_max[c] || m_idx[c] == 15) begin
                        e_wrap[c] = 1;
                        m_idx[c]  = 0;
                    end else begin
                        m_idx[c] = m_idx[c] + 1;
                    end
                end
                m_stb[c] = (((m_inc[c] * k) >> 4) != ((m_inc[c] * (k - 1)) >> 4)) ? 1 : 0;
            end
            tick();
            for (int c = 0; c < 2; c++) begin
                check($sformatf("stb%0d_k%0d", c, k), 64'(stb[c]), 64'(m_stb[c]));
                check($sformatf("idx%0d_k%0d", c, k), 64'(index[c*4 +: 4]), 64'(m_idx[c]));
                check($sformatf("wrap%0d_k%0d", c, k), 64'(wrap[c]), 64'(e_wrap[c]));
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        run      = 2'b00;
        inc_wr   = 2'b00;
        inc_data = 4'd0;
        clr      = 2'b00;
        idx_max  = {4'd15, 4'd3};
        repeat (2) @(posedge clk);
        #1;
        check("rst_stb", 64'(stb), 64'd0);
        check("rst_idx", 64'(index), 64'd0);
        check("rst_wrap", 64'(wrap), 64'd0);
        check("pkg_inc_2hz", calc_inc(46, 64'd2, 64'd48_000_000), 64'd2_932_031);
        check("pkg_inc_small", calc_inc(4, 64'd12_000_000, 64'd48_000_000), 64'd4);

        // inc=4 on ch0 (idx_max 3), inc=3 on ch1 (idx_max 15)
        reset = 1'b0;
        tick();
        inc_wr = 2'b01; inc_data = 4'd4;
        tick();
        inc_wr = 2'b10; inc_data = 4'd3;
        tick();
        inc_wr = 2'b00;
        run    = 2'b11;
        m_inc  = '{4, 3};
        m_max  = '{3, 15};
        run_start();
        run_edges(48);

        // clear both while writing inc=8 to ch0 in the same cycle
        clr = 2'b11; inc_wr = 2'b01; inc_data = 4'd8;
        tick();
        clr = 2'b00; inc_wr = 2'b00;
        check("clr_stb", 64'(stb), 64'd0);
        check("clr_idx", 64'(index), 64'd0);
        check("clr_wrap", 64'(wrap), 64'd0);
        m_inc = '{8, 3};
        run_start();
        run_edges(16);

        // clear ch0 on the edge that would carry; ch1 keeps going
        tick();
        check("pre_clr_stb0", 64'(stb[0]), 64'd0);
        clr = 2'b01;
        tick();
        clr = 2'b00;
        check("carry_clr_stb0", 64'(stb[0]), 64'd0);
        check("carry_clr_idx0", 64'(index[3:0]), 64'd0);
        check("carry_clr_wrap0", 64'(wrap[0]), 64'd0);
        check("carry_clr_idx1", 64'(index[7:4]), 64'd3);
        check("carry_clr_stb1", 64'(stb[1]), 64'd0);
        tick();
        check("post_clr_stb0_1", 64'(stb[0]), 64'd0);
        tick();
        check("post_clr_stb0_2", 64'(stb[0]), 64'd1);

        // asynchronous reset between edges, with a strobe in flight
        #2;
        reset = 1'b1;
        #1;
        check("arst_stb", 64'(stb), 64'd0);
        check("arst_idx", 64'(index), 64'd0);
        check("arst_wrap", 64'(wrap), 64'd0);
        #2;
        reset = 1'b0;
        m_inc = '{5, 5};
        run_start();
        run_edges(8);

        // pause: strobes stop, indices hold, accumulators resume from 8
        run = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_stb_%0d", i), 64'(stb), 64'd0);
            check($sformatf("hold_idx_%0d", i), 64'(index), 64'h22);
        end
        run = 2'b11;
        tick();
        check("resume_stb_1", 64'(stb), 64'd0);
        tick();
        check("resume_stb_2", 64'(stb), 64'h3);

        // lower idx_max below the running index: count on to 15, then roll over
        clr = 2'b11; inc_wr = 2'b01; inc_data = 4'd8; idx_max = {4'd15, 4'd15};
        tick();
        clr = 2'b00; inc_wr = 2'b00;
        m_inc = '{8, 5};
        m_max = '{15, 15};
        run_start();
        run_edges(12);
        idx_max[3:0] = 4'd2;
        m_max[0] = 2;
        run_edges(24);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
